// File: rtl/ahb_csr_arb.sv
// Round-robin arbiter sharing one CSR target port between N_REQ requesters.
// One access is in flight at a time; the granted requester is locked until the target completes.

module ahb_csr_arb_lane #(
  parameter int DATA_W = 32
) (
  input  logic              sel,
  input  logic              done,
  input  logic              rd,
  input  logic [DATA_W-1:0] rdata_in,
  output logic              ready,
  output logic [DATA_W-1:0] rdata
);
  assign ready = sel & done;
  assign rdata = (sel && done && rd) ? rdata_in : '0;
endmodule

module ahb_csr_arb #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    hclk_i,
  input  logic                    hreset_ni,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [N_REQ-1:0]        req_write_i,
  input  logic [N_REQ*DATA_W-1:0] req_wdata_i,
  output logic [N_REQ*DATA_W-1:0] req_rdata_o,
  output logic                    csr_valid_o,
  input  logic                    csr_ready_i,
  output logic [ADDR_W-1:0]       csr_addr_o,
  output logic                    csr_write_o,
  output logic [DATA_W-1:0]       csr_wdata_o,
  input  logic [DATA_W-1:0]       csr_rdata_i
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, BUSY} state_e;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
  } csr_req_t;

  logic [N_REQ-1:0][ADDR_W-1:0] addr_v;
  logic [N_REQ-1:0][DATA_W-1:0] wdata_v, rdata_v;
  state_e                       state_q, state_d;
  logic [IW-1:0]                rr_q, rr_d, gnt_q, gnt_d, win;
  logic [N_REQ-1:0]             rot;
  int                           off;
  csr_req_t                     req_q, req_d;
  logic                         done;

  assign addr_v  = req_addr_i;
  assign wdata_v = req_wdata_i;

  // Rotate requests so bit 0 is rr_q; the lowest set bit is the winner's offset.
  always_comb begin
    rot = N_REQ'({req_valid_i, req_valid_i} >> rr_q);
    off = 0;
    for (int k = N_REQ-1; k >= 0; k--)
      if (rot[k]) off = k;
    off = int'(rr_q) + off;
    if (off >= N_REQ) off = off - N_REQ;
    win = IW'(off);
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    req_d   = req_q;
    case (state_q)
      IDLE:
        if (|req_valid_i) begin
          state_d     = BUSY;
          gnt_d       = win;
          req_d.addr  = addr_v[win];
          req_d.write = req_write_i[win];
        end
      BUSY:
        if (csr_ready_i) begin
          state_d = IDLE;
          rr_d    = (int'(gnt_q) == N_REQ-1) ? '0 : gnt_q + IW'(1);
        end
    endcase
  end

  always_ff @(posedge hclk_i or negedge hreset_ni) begin
    if (!hreset_ni) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      gnt_q       <= '0;
      req_q.addr  <= '1;
      req_q.write <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      req_q   <= req_d;
    end
  end

  assign csr_valid_o = (state_q == BUSY);
  assign csr_addr_o  = req_q.addr;
  assign csr_write_o = req_q.write;
  // Write data is not registered: a requester may present it after the grant.
  assign csr_wdata_o = wdata_v[gnt_q];
  assign done        = csr_valid_o & csr_ready_i;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    ahb_csr_arb_lane #(.DATA_W(DATA_W)) u_lane (
      .sel      (csr_valid_o && (gnt_q == IW'(i))),
      .done     (done),
      .rd       (!req_q.write),
      .rdata_in (csr_rdata_i),
      .ready    (req_ready_o[i]),
      .rdata    (rdata_v[i])
    );
  end

  assign req_rdata_o = rdata_v;

  if (N_REQ < 1) begin : g_bad_n_req
    $error("ahb_csr_arb: N_REQ must be >= 1");
  end

`ifndef SYNTHESIS
  a_ready_onehot: assert property (@(posedge hclk_i) disable iff (!hreset_ni)
    $onehot0(req_ready_o));
  a_csr_stable: assert property (@(posedge hclk_i) disable iff (!hreset_ni)
    csr_valid_o && !csr_ready_i |=> $stable(csr_addr_o) && $stable(csr_write_o));
  // Granted requester must hold valid until it sees ready.
  a_req_held: assert property (@(posedge hclk_i) disable iff (!hreset_ni)
    csr_valid_o |-> req_valid_i[gnt_q]);
`endif
endmodule

// File: tb/tb_ahb_csr_arb.sv
// Bench for ahb_csr_arb: directed scenarios on N_REQ=2/3 plus a randomized run
// on N_REQ=3 checked against a transaction-level round-robin model.
module tb_ahb_csr_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [1:0]       v2, rdy2, wr2;
  logic [1:0][31:0] a2, wd2, rd2;
  logic             cv2, cr2, cw2;
  logic [31:0]      ca2, cwd2, crd2;

  logic [2:0]       v3, rdy3, wr3;
  logic [2:0][31:0] a3, wd3, rd3;
  logic             cv3, cr3, cw3;
  logic [31:0]      ca3, cwd3, crd3;

  ahb_csr_arb #(.N_REQ(2), .ADDR_W(32), .DATA_W(32)) dut2 (
    .hclk_i(clk), .hreset_ni(rst_n),
    .req_valid_i(v2), .req_ready_o(rdy2), .req_addr_i(a2), .req_write_i(wr2),
    .req_wdata_i(wd2), .req_rdata_o(rd2),
    .csr_valid_o(cv2), .csr_ready_i(cr2), .csr_addr_o(ca2), .csr_write_o(cw2),
    .csr_wdata_o(cwd2), .csr_rdata_i(crd2));

  ahb_csr_arb #(.N_REQ(3), .ADDR_W(32), .DATA_W(32)) dut3 (
    .hclk_i(clk), .hreset_ni(rst_n),
    .req_valid_i(v3), .req_ready_o(rdy3), .req_addr_i(a3), .req_write_i(wr3),
    .req_wdata_i(wd3), .req_rdata_o(rd3),
    .csr_valid_o(cv3), .csr_ready_i(cr3), .csr_addr_o(ca3), .csr_write_o(cw3),
    .csr_wdata_o(cwd3), .csr_rdata_i(crd3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    v2 = '0; a2 = '0; wr2 = '0; wd2 = '0; cr2 = 1'b0; crd2 = '0;
    v3 = '0; a3 = '0; wr3 = '0; wd3 = '0; cr3 = 1'b0; crd3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (cv2 !== 1'b0) begin failures++; $display("FAIL reset_cv2 got=%h want=0", cv2); end
    checks++; if (ca2 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_addr2 got=%h want=ffffffff", ca2); end
    checks++; if (cw2 !== 1'b0) begin failures++; $display("FAIL reset_write2 got=%h want=0", cw2); end
    checks++; if (rdy2 !== 2'b00 || rd2 !== '0) begin failures++; $display("FAIL reset_req2 rdy=%h rdata=%h want 0/0", rdy2, rd2); end
    checks++; if (cv3 !== 1'b0 || ca3 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_dut3 cv=%h addr=%h want 0/ffffffff", cv3, ca3); end
  endtask

  task automatic test_single_read();
    tick();
    v2 = 2'b01; a2[0] = 32'h10; a2[1] = 32'h77; wr2 = 2'b00; cr2 = 1'b1; crd2 = 32'hCAFE_0001;
    samp();
    checks++; if (cv2 !== 1'b0) begin failures++; $display("FAIL single_idle_cv got=%h want=0", cv2); end
    tick(); samp();
    checks++; if (cv2 !== 1'b1 || ca2 !== 32'h10 || cw2 !== 1'b0) begin failures++; $display("FAIL single_busy cv=%h addr=%h wr=%h want 1/10/0", cv2, ca2, cw2); end
    checks++; if (rdy2 !== 2'b01) begin failures++; $display("FAIL single_ready got=%b want=01", rdy2); end
    checks++; if (rd2[0] !== 32'hCAFE_0001) begin failures++; $display("FAIL single_rdata0 got=%h want=cafe0001", rd2[0]); end
    checks++; if (rd2[1] !== 32'h0) begin failures++; $display("FAIL single_rdata1 got=%h want=0", rd2[1]); end
    tick(); v2 = 2'b00;
    samp();
    checks++; if (cv2 !== 1'b0 || rdy2 !== 2'b00) begin failures++; $display("FAIL single_after cv=%h rdy=%b want 0/00", cv2, rdy2); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tick();
    v2 = 2'b11; a2[0] = 32'h100; a2[1] = 32'h200; wr2 = 2'b00; cr2 = 1'b1; crd2 = 32'h1234_5678;
    samp();
    checks++; if (cv2 !== 1'b0) begin failures++; $display("FAIL b2b_first_cv got=%h want=0", cv2); end
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 7) v2 = 2'b00;
      samp();
      checks++; if (cv2 !== ((k % 2) == 0)) begin failures++; $display("FAIL b2b_cv k=%0d got=%h want=%0d", k, cv2, (k % 2) == 0); end
      if ((k % 2) == 0) begin
        int g;
        g = (k / 2) % 2;
        checks++;
        if (ca2 !== ((g == 1) ? 32'h200 : 32'h100) || rdy2 !== (2'b01 << g)) begin
          failures++; $display("FAIL b2b_grant k=%0d addr=%h rdy=%b want grant %0d", k, ca2, rdy2, g);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    tick();
    v2 = 2'b01; a2[0] = 32'h20; wr2 = 2'b01; wd2[0] = 32'h55; cr2 = 1'b0; crd2 = 32'hDEAD_BEEF;
    samp();
    checks++; if (cv2 !== 1'b0) begin failures++; $display("FAIL bp_idle_cv got=%h want=0", cv2); end
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) cr2 = 1'b1;
      samp();
      checks++;
      if (cv2 !== 1'b1 || ca2 !== 32'h20 || cw2 !== 1'b1 || cwd2 !== 32'h55) begin
        failures++; $display("FAIL bp_hold k=%0d cv=%h addr=%h wr=%h wdata=%h want 1/20/1/55", k, cv2, ca2, cw2, cwd2);
      end
      checks++; if (rdy2 !== ((k == 3) ? 2'b01 : 2'b00)) begin failures++; $display("FAIL bp_ready k=%0d got=%b", k, rdy2); end
    end
    checks++; if (rd2 !== '0) begin failures++; $display("FAIL bp_write_rdata got=%h want=0", rd2); end
    tick(); v2 = 2'b00; wr2 = 2'b00;
    samp();
    checks++; if (cv2 !== 1'b0) begin failures++; $display("FAIL bp_done_cv got=%h want=0", cv2); end
  endtask

  task automatic test_write_rdata();
    tick();
    v2 = 2'b01; wr2 = 2'b01; a2[0] = 32'h44; wd2[0] = 32'h1234; cr2 = 1'b1; crd2 = 32'hFFFF_FFFF;
    samp(); tick(); samp();
    checks++; if (rdy2 !== 2'b01) begin failures++; $display("FAIL wr_ready got=%b want=01", rdy2); end
    checks++; if (rd2 !== '0) begin failures++; $display("FAIL wr_rdata got=%h want=0", rd2); end
    checks++; if (cwd2 !== 32'h1234 || cw2 !== 1'b1) begin failures++; $display("FAIL wr_wdata got=%h/%h want 1234/1", cwd2, cw2); end
    tick(); v2 = 2'b00; wr2 = 2'b00;
  endtask

  task automatic test_rr_wrap();
    int exp_g[3] = '{2, 0, 2};
    do_reset();
    tick();
    v3 = 3'b010; a3[1] = 32'h1; cr3 = 1'b1;
    samp(); tick(); samp();
    checks++; if (rdy3 !== 3'b010) begin failures++; $display("FAIL wrap_first got=%b want=010", rdy3); end
    tick();
    v3 = 3'b101; a3[0] = 32'hA0; a3[2] = 32'hA2;
    samp();
    checks++; if (cv3 !== 1'b0) begin failures++; $display("FAIL wrap_gap got=%h want=0", cv3); end
    for (int j = 0; j < 3; j++) begin
      tick(); samp();
      checks++;
      if (ca3 !== ((exp_g[j] == 2) ? 32'hA2 : 32'hA0) || rdy3 !== (3'b001 << exp_g[j])) begin
        failures++; $display("FAIL wrap_grant j=%0d addr=%h rdy=%b want grant %0d", j, ca3, rdy3, exp_g[j]);
      end
      tick();
      if (j == 2) v3 = 3'b000;
      samp();
      checks++; if (cv3 !== 1'b0) begin failures++; $display("FAIL wrap_idle j=%0d cv=%h want=0", j, cv3); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick();
    v2 = 2'b01; a2[0] = 32'h30; a2[1] = 32'h40; wr2 = 2'b00; cr2 = 1'b1;
    samp(); tick(); samp();
    checks++; if (ca2 !== 32'h30) begin failures++; $display("FAIL rmid_pre0 addr=%h want=30", ca2); end
    tick();
    v2 = 2'b10; cr2 = 1'b0;
    samp(); tick(); samp();
    checks++; if (cv2 !== 1'b1 || ca2 !== 32'h40) begin failures++; $display("FAIL rmid_busy1 cv=%h addr=%h want 1/40", cv2, ca2); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (cv2 !== 1'b0 || ca2 !== 32'hFFFF_FFFF || cw2 !== 1'b0 || rdy2 !== 2'b00) begin
      failures++; $display("FAIL rmid_async cv=%h addr=%h wr=%h rdy=%b want 0/ffffffff/0/00", cv2, ca2, cw2, rdy2);
    end
    tick();
    v2 = 2'b11; cr2 = 1'b1;
    samp();
    rst_n = 1'b1;
    tick(); samp();
    checks++; if (ca2 !== 32'h30 || rdy2 !== 2'b01) begin failures++; $display("FAIL rmid_post addr=%h rdy=%b want 30/01", ca2, rdy2); end
    tick(); v2 = 2'b00;
    samp();
  endtask

  task automatic test_random();
    bit          pend[3], done_r[3], snap[3], rw[3];
    logic [31:0] ra[3], rwd[3];
    int          served[3];
    int          rr, cur;
    bit          prev_cv, prev_done, exp_cv;
    logic [2:0]       exp_rdy;
    logic [2:0][31:0] exp_rd;
    do_reset();
    rr = 0; cur = 0; prev_cv = 1'b0; prev_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pend[i] = 1'b0; done_r[i] = 1'b0; rw[i] = 1'b0; ra[i] = '0; rwd[i] = '0; served[i] = 0;
    end
    repeat (600) begin
      tick();
      snap = pend;
      for (int i = 0; i < 3; i++) begin
        if (done_r[i]) begin pend[i] = 1'b0; done_r[i] = 1'b0; end
        if (!pend[i] && $urandom_range(3) == 0) begin
          pend[i] = 1'b1; ra[i] = $urandom; rw[i] = 1'($urandom_range(1)); rwd[i] = $urandom;
        end
        v3[i] = pend[i]; a3[i] = ra[i]; wr3[i] = rw[i]; wd3[i] = rwd[i];
      end
      cr3 = ($urandom_range(2) != 0);
      crd3 = $urandom;
      samp();
      // Next state from the previous cycle: idle picks round-robin, busy holds until ready.
      if (!prev_cv) begin
        exp_cv = 1'b0;
        for (int k = 0; k < 3; k++) begin
          int idx;
          idx = (rr + k) % 3;
          if (!exp_cv && snap[idx]) begin cur = idx; exp_cv = 1'b1; end
        end
      end else begin
        exp_cv = !prev_done;
      end
      checks++; if (cv3 !== exp_cv) begin failures++; $display("FAIL rand_cv got=%h want=%h", cv3, exp_cv); end
      exp_rdy = '0; exp_rd = '0;
      if (exp_cv) begin
        checks++;
        if (ca3 !== ra[cur] || cw3 !== rw[cur] || cwd3 !== rwd[cur]) begin
          failures++; $display("FAIL rand_target req=%0d addr=%h wr=%h wdata=%h want %h/%h/%h", cur, ca3, cw3, cwd3, ra[cur], rw[cur], rwd[cur]);
        end
        if (cr3) begin
          exp_rdy = 3'b001 << cur;
          for (int i = 0; i < 3; i++)
            if (i == cur && !rw[cur]) exp_rd[i] = crd3;
        end
      end
      checks++; if (rdy3 !== exp_rdy) begin failures++; $display("FAIL rand_ready got=%b want=%b", rdy3, exp_rdy); end
      checks++; if (rd3 !== exp_rd) begin failures++; $display("FAIL rand_rdata got=%h want=%h", rd3, exp_rd); end
      prev_done = exp_cv && cr3;
      if (prev_done) begin done_r[cur] = 1'b1; rr = (cur + 1) % 3; served[cur]++; end
      prev_cv = exp_cv;
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (served[i] == 0) begin failures++; $display("FAIL rand_served req=%0d got=0 want>0", i); end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_backpressure();
    test_write_rdata();
    test_rr_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
